mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single memory port (cyc/we/adr/dat -> ack) between N_REQ cache-side masters.
//  Masters are typically the I-cache and D-cache controllers, or a controller plus the MSHR writeback path.
//  Arbitration is round-robin. Each grant holds for exactly one transfer, until ack, abort or timeout.
//  Adds one cycle of arbitration latency. A per-transfer watchdog reports err to the master.
// PARAMETERS
//  N_REQ    2    number of masters (>=2)
//  ADR_W    32   address width
//  DAT_W    32   data width
//  TIMEOUT  255  BUSY cycles without ack before err; 0 = watchdog disabled
// PORTS
//  clk        in   1            clock; all state on posedge
//  rst        in   1            synchronous, active-high reset
//  cyc_i      in   N_REQ        per-master request; held until ack_o/err_o
//  we_i       in   N_REQ        per-master write enable
//  adr_i      in   N_REQ*ADR_W  packed addresses; master k at [k*ADR_W +: ADR_W]
//  dat_i      in   N_REQ*DAT_W  packed write data
//  dat_o      out  DAT_W        read data, broadcast to all masters (= dat_mem_i)
//  ack_o      out  N_REQ        one-hot transfer-done strobe
//  err_o      out  N_REQ        one-hot timeout strobe
//  grant_o    out  N_REQ        one-hot current owner; 0 when IDLE
//  cyc_m2s    out  1            to memory
//  we_m2s     out  1            to memory
//  adr_m2s    out  ADR_W        to memory
//  dat_m2s    out  DAT_W        to memory
//  dat_mem_i  in   DAT_W        from memory
//  ack_mem_i  in   1            from memory
// BEHAVIOUR
//  Reset:
//   - state=IDLE; grant=0; last=N_REQ-1, so master 0 has first priority; wdog=0.
//   - Every output is 0 except dat_o, which tracks dat_mem_i.
//   - Reset during BUSY drops cyc_m2s in the next cycle. No ack_o or err_o is issued.
//  FSM IDLE -> BUSY:
//   - In IDLE, if |cyc_i, the winner is the first set bit scanning last+1, last+2, ... modulo N_REQ.
//   - grant<=onehot(winner); state<=BUSY; wdog<=0.
//  BUSY outputs:
//   - cyc_m2s=1. we/adr/dat_m2s are muxed combinationally from the registered grant.
//   - In IDLE, cyc_m2s=0 and we/adr/dat_m2s=0.
//  BUSY exits (g = granted index):
//   - ack_mem_i=1: ack_o[g]=1 in the same cycle (combinational); state<=IDLE; last<=g; grant<=0.
//   - else cyc_i[g]=0 (abort): state<=IDLE; last<=g; no ack_o or err_o.
//   - else TIMEOUT!=0 and wdog==TIMEOUT-1: err_o[g]=1 this cycle; state<=IDLE; last<=g.
//   - else wdog<=wdog+1. wdog is $clog2(TIMEOUT+1) bits wide and never wraps.
//  Priority among exits in one cycle: ack > abort > timeout.
//  Latency: cyc_i rise -> cyc_m2s rise is 1 cycle. ack_mem_i -> ack_o is 0 cycles.
//  ack_mem_i in IDLE is ignored. ack_o and err_o are never driven in IDLE.
//  Back-to-back:
//   - There is always at least one IDLE cycle (cyc_m2s=0) between transfers.
//   - A master still holding cyc_i in the cycle after its ack is a new request.
//   - That new request loses to any other pending master.
//  ack_o and err_o are one-hot or zero. grant_o is one-hot or zero.
// STRUCTURE
//  Shared package cache_pkg holds:
//   - FSM encoding localparams IDLE=1'b0, BUSY=1'b1.
//   - Default ADR_W and DAT_W, shared with the cache controller and MSHR.
//  Sub-module rr_pick #(N): combinational. Inputs req[N] and last index; outputs onehot and index.
//  Packing and unpacking of the master buses is done with generate loops in mem_bus_arbiter.
// TESTING
//  T1 single master:
//   - Stimulus: m0 cyc, we=0, adr=0x40; memory acks 3 cycles after cyc_m2s with dat 0xDEAD.
//   - Required: cyc_m2s 1 cycle after cyc_i; ack_o=01 with dat_o=0xDEAD; cyc_m2s=0 next cycle.
//  T2 round-robin fairness:
//   - Stimulus: m0 and m1 request continuously; memory acks after 1 cycle.
//   - Required: grants alternate 01,10,01,10 starting with m0 after reset.
//   - Required: exactly one IDLE cycle between grants.
//  T3 write routing:
//   - Stimulus: m1 only, we=1, adr=0x80, dat=0x1234.
//   - Required: we_m2s=1, adr_m2s=0x80, dat_m2s=0x1234 while BUSY; ack_o=10.
//  T4 timeout (TIMEOUT=4):
//   - Stimulus: m0 requests; memory never acks.
//   - Required: err_o=01 on the 4th BUSY cycle; then IDLE.
//  T5 ack beats timeout (TIMEOUT=4):
//   - Stimulus: ack_mem_i in the same cycle as the timeout.
//   - Required: ack_o=01, err_o=00.
//  T6 abort and reset:
//   - Stimulus: m1 drops cyc mid-BUSY -> Required: IDLE next cycle, no ack_o.
//   - Stimulus: rst asserted mid-BUSY -> Required: all outputs 0; next grant goes to m0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache-side memory subsystem.
// Used by the controller, the MSHR and the memory bus arbiter.
package cache_pkg;

   localparam logic IDLE_ENC = 1'b0;
   localparam logic BUSY_ENC = 1'b1;

   typedef enum logic {
      IDLE = IDLE_ENC,
      BUSY = BUSY_ENC
   } arb_state_e;

   localparam int ADR_W_DEF = 32;
   localparam int DAT_W_DEF = 32;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request buses plus the single memory port of the arbiter.
// The slave modport is the arbiter's view; master is the masters/memory view.
interface mem_bus_arbiter_if #(
   parameter int N_REQ = 2,
   parameter int ADR_W = cache_pkg::ADR_W_DEF,
   parameter int DAT_W = cache_pkg::DAT_W_DEF
);
   logic [N_REQ-1:0]       cyc_i;
   logic [N_REQ-1:0]       we_i;
   logic [N_REQ*ADR_W-1:0] adr_i;
   logic [N_REQ*DAT_W-1:0] dat_i;
   logic [DAT_W-1:0]       dat_o;
   logic [N_REQ-1:0]       ack_o;
   logic [N_REQ-1:0]       err_o;
   logic [N_REQ-1:0]       grant_o;
   logic                   cyc_m2s;
   logic                   we_m2s;
   logic [ADR_W-1:0]       adr_m2s;
   logic [DAT_W-1:0]       dat_m2s;
   logic [DAT_W-1:0]       dat_mem_i;
   logic                   ack_mem_i;

   modport slave (
      input  cyc_i, we_i, adr_i, dat_i, dat_mem_i, ack_mem_i,
      output dat_o, ack_o, err_o, grant_o, cyc_m2s, we_m2s, adr_m2s, dat_m2s
   );

   modport master (
      output cyc_i, we_i, adr_i, dat_i, dat_mem_i, ack_mem_i,
      input  dat_o, ack_o, err_o, grant_o, cyc_m2s, we_m2s, adr_m2s, dat_m2s
   );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request bit scanning last+1, last+2, ... mod N.
module rr_pick #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] index
);

   always_comb begin
      int          j;
      logic [IW-1:0] jj;
      logic        found;
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      j      = 0;
      jj     = '0;
      for (int i = 1; i <= N; i++) begin
         j = int'(last) + i;
         if (j >= N) j = j - N;
         jj = IW'(j);
         if (!found && req[jj]) begin
            found      = 1'b1;
            onehot[jj] = 1'b1;
            index      = jj;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among N_REQ cache-side masters.
// One transfer per grant; ends on ack, master abort or watchdog timeout.
module mem_bus_arbiter import cache_pkg::*; #(
   parameter int N_REQ   = 2,
   parameter int ADR_W   = ADR_W_DEF,
   parameter int DAT_W   = DAT_W_DEF,
   parameter int TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e                  state, state_nx;
   logic [N_REQ-1:0]            grant, grant_nx;
   logic [IDX_W-1:0]            gidx, gidx_nx, last, last_nx;
   logic [WD_W-1:0]             wdog, wdog_nx;
   logic [N_REQ-1:0]            pick_oh;
   logic [IDX_W-1:0]            pick_idx;
   logic                        wd_hit;
   logic [N_REQ-1:0][ADR_W-1:0] adr_arr;
   logic [N_REQ-1:0][DAT_W-1:0] dat_arr;
   logic [ADR_W-1:0]            adr_mux;
   logic [DAT_W-1:0]            dat_mux;
   logic                        we_mux;

   rr_pick #(.N(N_REQ)) u_pick (
      .req    (bus.cyc_i),
      .last   (last),
      .onehot (pick_oh),
      .index  (pick_idx)
   );

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign adr_arr[k] = bus.adr_i[k*ADR_W +: ADR_W];
      assign dat_arr[k] = bus.dat_i[k*DAT_W +: DAT_W];
   end

   if (TIMEOUT > 0) begin : g_wd
      assign wd_hit = (wdog == WD_W'(TIMEOUT - 1));
   end else begin : g_nowd
      assign wd_hit = 1'b0;
   end

   // AND-OR mux on the one-hot grant; zero grant in IDLE zeroes the memory bus
   always_comb begin
      adr_mux = '0;
      dat_mux = '0;
      we_mux  = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant[k]) begin
            adr_mux = adr_mux | adr_arr[k];
            dat_mux = dat_mux | dat_arr[k];
            we_mux  = we_mux  | bus.we_i[k];
         end
      end
   end

   always_comb begin
      state_nx  = state;
      grant_nx  = grant;
      gidx_nx   = gidx;
      last_nx   = last;
      wdog_nx   = wdog;
      bus.ack_o = '0;
      bus.err_o = '0;
      case (state)
         IDLE: begin
            if (|bus.cyc_i) begin
               state_nx = BUSY;
               grant_nx = pick_oh;
               gidx_nx  = pick_idx;
               wdog_nx  = '0;
            end
         end
         BUSY: begin
            if (bus.ack_mem_i || !bus.cyc_i[gidx] || wd_hit) begin
               state_nx = IDLE;
               grant_nx = '0;
               last_nx  = gidx;
               if (bus.ack_mem_i)        bus.ack_o = grant;
               else if (bus.cyc_i[gidx]) bus.err_o = grant;
            end else if (wdog != '1) begin
               wdog_nx = wdog + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // A transfer cut short by reset completes nothing
      if (rst) begin
         bus.ack_o = '0;
         bus.err_o = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         gidx  <= '0;
         last  <= IDX_W'(N_REQ - 1);
         wdog  <= '0;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         gidx  <= gidx_nx;
         last  <= last_nx;
         wdog  <= wdog_nx;
      end
   end

   assign bus.grant_o = grant;
   assign bus.cyc_m2s = (state == BUSY);
   assign bus.we_m2s  = we_mux;
   assign bus.adr_m2s = adr_mux;
   assign bus.dat_m2s = dat_mux;
   assign bus.dat_o   = bus.dat_mem_i;

endmodule
